// File: rtl/mod107_pkg.sv
// Shared modulus constants, residue type and the single-step mod-107 reduction
// used by the residue accumulation tree.
package mod107_pkg;

    localparam int MODULUS = 107;
    localparam int RES_W   = 7;

    typedef logic [RES_W-1:0] residue_t;

    // Valid only for inputs below 2*MODULUS: one conditional subtract suffices.
    function automatic residue_t mod107_reduce(input logic [7:0] s);
        logic [7:0] diff;
        diff = s - 8'(MODULUS);
        if (s >= 8'(MODULUS)) begin
            return diff[RES_W-1:0];
        end
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mod107_add.sv
// Combinational modular adder: (a + b) mod 107 for operands already in 0..106.
module mod107_add
    import mod107_pkg::*;
(
    input  logic [6:0] a,
    input  logic [6:0] b,
    output logic [6:0] sum
);

    logic [7:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sum = mod107_reduce(raw);

endmodule

// File: rtl/mod107_residue_accumulator.sv
// Streams weighted chunk residues over valid/ready, keeps a running sum mod 107
// and holds one result per frame with range and length error flags.
module mod107_residue_accumulator
    import mod107_pkg::*;
#(
    parameter int N_CHUNKS = 84,
    parameter int CNT_W    = $clog2(N_CHUNKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_residue,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_residue,
    output logic [CNT_W-1:0] out_count,
    output logic             out_range_err,
    output logic             out_len_err
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] N_CHUNKS_C = CNT_W'(N_CHUNKS);

    state_t           state;
    state_t           next_state;
    residue_t         acc;
    logic [CNT_W-1:0] cnt;
    logic             range_flag;

    residue_t         r_red;
    residue_t         acc_sum;
    logic             in_range;
    logic [CNT_W-1:0] cnt_inc;
    logic             range_next;

    logic             accept;
    logic             latch;
    logic             clear;

    // Out-of-range inputs (107..127) fold back once and poison the frame.
    assign in_range   = in_residue >= 7'(MODULUS);
    assign r_red      = mod107_reduce({1'b0, in_residue});
    assign range_next = range_flag | in_range;
    assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    mod107_add u_add (
        .a   (acc),
        .b   (r_red),
        .sum (acc_sum)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        latch      = 1'b0;
        clear      = 1'b0;
        case (state)
            ACCUM: begin
                if (clr) begin
                    clear = 1'b1;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (in_last) begin
                        latch      = 1'b1;
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = ACCUM;
                end
            end
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            range_flag <= 1'b0;
        end else if (clear || latch) begin
            acc        <= '0;
            cnt        <= '0;
            range_flag <= 1'b0;
        end else if (accept) begin
            acc        <= acc_sum;
            cnt        <= cnt_inc;
            range_flag <= range_next;
        end
    end

    // Result registers only change when a frame closes, so they stay stable in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_residue   <= '0;
            out_count     <= '0;
            out_range_err <= 1'b0;
            out_len_err   <= 1'b0;
        end else if (latch) begin
            out_residue   <= acc_sum;
            out_count     <= cnt_inc;
            out_range_err <= range_next;
            out_len_err   <= (cnt_inc != N_CHUNKS_C);
        end
    end

endmodule
